// File: rtl/vec_irq_arbiter_pkg.sv
// Shared types and constants for the vectored-interrupt arbiter.
// Holds the FSM encoding, the selected-source encoding and the vector width.
package vec_irq_pkg;

    localparam int VEC_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit 4 set marks "no source latched"; indices 0..15 fit in the low bits.
    typedef logic [4:0] sel_t;
    localparam sel_t SEL_NONE = 5'h10;

    function automatic int win_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_irq_arbiter_if.sv
// Bundle of peripheral request lines and the CPU vector-fetch handshake.
// The arbiter is the slave (responder); the CPU/peripheral side is the master.
interface vec_irq_arbiter_if
    import vec_irq_pkg::*;
#(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0]       irq_req;
    logic [VEC_W*N_SRC-1:0] irq_vec;
    logic [N_SRC-1:0]       irq_ack;
    logic                   virq;
    logic                   istb;
    logic [VEC_W-1:0]       ivec;
    logic                   iack;

    modport slave (
        input  irq_req, irq_vec, istb,
        output irq_ack, virq, ivec, iack
    );

    modport master (
        output irq_req, irq_vec, istb,
        input  irq_ack, virq, ivec, iack
    );
endinterface

// File: rtl/vec_irq_arbiter_prio_enc.sv
// Combinational fixed-priority encoder: lowest set request index wins.
module irq_prio_enc
    import vec_irq_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int WIN_W = win_width(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    output logic [WIN_W-1:0] win_o,
    output logic             pend_o
);

    // Scan from the top down so the lowest index is the last one written.
    always_comb begin
        win_o = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                win_o = WIN_W'(k);
            end
        end
    end

    assign pend_o = |req_i;

endmodule

// File: rtl/vec_irq_arbiter.sv
// Responder end of the CPU vectored-interrupt interface: arbitrates level
// requests, answers the vector fetch and pulses the serviced source's ack.
module vec_irq_arbiter
    import vec_irq_pkg::*;
#(
    parameter int               N_SRC   = 4,
    parameter logic [VEC_W-1:0] DEF_VEC = 16'd0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    vec_irq_arbiter_if.slave bus
);

    localparam int WIN_W = win_width(N_SRC);

    logic [WIN_W-1:0] win;
    logic             pend;
    sel_t             win_sel;

    state_t           state_q, state_d;
    sel_t             sel_q, sel_d;
    logic             virq_q, virq_d;
    logic             iack_r_q, iack_r_d;
    logic [VEC_W-1:0] ivec_q, ivec_d;
    logic [N_SRC-1:0] irq_ack_q, irq_ack_d;
    logic             in_ack;
    logic [VEC_W-1:0] sel_vec;

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .WIN_W (WIN_W)
    ) u_enc (
        .req_i  (bus.irq_req),
        .win_o  (win),
        .pend_o (pend)
    );

    assign win_sel = sel_t'(win);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= IDLE;
            sel_q     <= SEL_NONE;
            virq_q    <= 1'b0;
            iack_r_q  <= 1'b0;
            ivec_q    <= '0;
            irq_ack_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            virq_q    <= virq_d;
            iack_r_q  <= iack_r_d;
            ivec_q    <= ivec_d;
            irq_ack_q <= irq_ack_d;
        end
    end

    // The winner is only latched on the fetch edge; afterwards sel_q is frozen.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (bus.istb) begin
                    state_d = ACK;
                    sel_d   = SEL_NONE;
                end else if (pend) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (bus.istb) begin
                    state_d = ACK;
                    sel_d   = pend ? win_sel : SEL_NONE;
                end else if (!pend) begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (!bus.istb) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sel_vec = DEF_VEC;
        for (int k = 0; k < N_SRC; k++) begin
            if (sel_q == sel_t'(k)) begin
                sel_vec = bus.irq_vec[VEC_W*k +: VEC_W];
            end
        end
    end

    // First ACK cycle is the wait state; iack_r_q low there marks the one-shot edge.
    always_comb begin
        in_ack    = (state_q == ACK) && (state_d == ACK);
        virq_d    = (state_q == PEND) && (state_d == PEND);
        iack_r_d  = in_ack;
        ivec_d    = '0;
        irq_ack_d = '0;
        if (in_ack) begin
            ivec_d = iack_r_q ? ivec_q : sel_vec;
            for (int k = 0; k < N_SRC; k++) begin
                irq_ack_d[k] = !iack_r_q && (sel_q == sel_t'(k));
            end
        end
    end

    assign bus.virq    = virq_q;
    assign bus.ivec    = ivec_q;
    assign bus.irq_ack = irq_ack_q;
    assign bus.iack    = iack_r_q & bus.istb;

endmodule

// File: tb/tb_vec_irq_arbiter.sv
// Directed bench for vec_irq_arbiter: reset, single source, priority,
// fetch freeze, spurious fetch / withdrawal and reset in mid-fetch.
module tb_vec_irq_arbiter;
    import vec_irq_pkg::*;

    localparam logic [15:0] TB_DEF_VEC = 16'hDEAD;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    vec_irq_arbiter_if #(.N_SRC(4)) bus ();

    vec_irq_arbiter #(
        .N_SRC   (4),
        .DEF_VEC (TB_DEF_VEC)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic stb);
        bus.irq_req = req;
        bus.istb    = stb;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic virq, input logic iack,
                            input logic [15:0] ivec, input logic [3:0] ack);
        checkOutput({tag, ".virq"}, 32'(bus.virq), 32'(virq));
        checkOutput({tag, ".iack"}, 32'(bus.iack), 32'(iack));
        checkOutput({tag, ".ivec"}, 32'(bus.ivec), 32'(ivec));
        checkOutput({tag, ".irq_ack"}, 32'(bus.irq_ack), 32'(ack));
    endtask

    initial begin
        clk        = 1'b0;
        checkCount = 0;
        errorCount = 0;
        bus.irq_vec = {16'o000100, 16'o000060, 16'o000064, 16'o000070};

        $display("[TB] reset held with all requests and strobe high");
        rst_n = 1'b0;
        applyStimulus(4'b1111, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkAll("reset", 1'b0, 1'b0, 16'h0000, 4'b0000);
        end
        applyStimulus(4'b0000, 1'b0);
        rst_n = 1'b1;
        tick();

        $display("[TB] single source 2");
        applyStimulus(4'b0100, 1'b0);
        tick();
        checkOutput("single.virq_edge1", 32'(bus.virq), 32'd0);
        tick();
        checkOutput("single.virq_edge2", 32'(bus.virq), 32'd1);
        applyStimulus(4'b0100, 1'b1);
        tick();
        checkAll("single.wait", 1'b0, 1'b0, 16'h0000, 4'b0000);
        tick();
        checkAll("single.ack", 1'b0, 1'b1, 16'o000060, 4'b0100);
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkAll("single.hold", 1'b0, 1'b1, 16'o000060, 4'b0000);
        applyStimulus(4'b0000, 1'b0);
        #1;
        checkOutput("single.iack_drop", 32'(bus.iack), 32'd0);
        tick();
        checkAll("single.done", 1'b0, 1'b0, 16'h0000, 4'b0000);
        tick();

        $display("[TB] priority between sources 1 and 3");
        applyStimulus(4'b1010, 1'b0);
        tick();
        tick();
        checkOutput("prio.virq", 32'(bus.virq), 32'd1);
        applyStimulus(4'b1010, 1'b1);
        tick();
        tick();
        checkAll("prio.first", 1'b0, 1'b1, 16'o000064, 4'b0010);
        applyStimulus(4'b1000, 1'b0);
        #1;
        checkOutput("prio.iack_drop", 32'(bus.iack), 32'd0);
        tick();
        tick();
        checkOutput("prio.holdoff", 32'(bus.virq), 32'd0);
        tick();
        checkOutput("prio.pend_edge1", 32'(bus.virq), 32'd0);
        tick();
        checkOutput("prio.pend_edge2", 32'(bus.virq), 32'd1);
        applyStimulus(4'b1000, 1'b1);
        tick();
        tick();
        checkAll("prio.second", 1'b0, 1'b1, 16'o000100, 4'b1000);

        $display("[TB] freeze of selection during ACK");
        applyStimulus(4'b1001, 1'b1);
        tick();
        checkAll("freeze.raise0", 1'b0, 1'b1, 16'o000100, 4'b0000);
        applyStimulus(4'b0001, 1'b1);
        tick();
        checkAll("freeze.hold", 1'b0, 1'b1, 16'o000100, 4'b0000);
        applyStimulus(4'b0001, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("freeze.pend_edge1", 32'(bus.virq), 32'd0);
        tick();
        checkOutput("freeze.pend_edge2", 32'(bus.virq), 32'd1);
        applyStimulus(4'b0001, 1'b1);
        tick();
        tick();
        checkAll("freeze.src0", 1'b0, 1'b1, 16'o000070, 4'b0001);
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();

        $display("[TB] withdrawal and spurious fetch");
        applyStimulus(4'b0001, 1'b0);
        tick();
        tick();
        checkOutput("withdraw.virq_up", 32'(bus.virq), 32'd1);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("withdraw.virq_down", 32'(bus.virq), 32'd0);
        applyStimulus(4'b0000, 1'b1);
        tick();
        tick();
        checkAll("spurious", 1'b0, 1'b1, TB_DEF_VEC, 4'b0000);
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();

        $display("[TB] reset during a fetch");
        applyStimulus(4'b0100, 1'b0);
        tick();
        tick();
        applyStimulus(4'b0100, 1'b1);
        tick();
        tick();
        checkAll("rstfetch.ack", 1'b0, 1'b1, 16'o000060, 4'b0100);
        #1;
        rst_n = 1'b0;
        #1;
        checkAll("rstfetch.in_reset", 1'b0, 1'b0, 16'h0000, 4'b0000);
        applyStimulus(4'b0100, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("rstfetch.virq_edge1", 32'(bus.virq), 32'd0);
        tick();
        checkOutput("rstfetch.virq_edge2", 32'(bus.virq), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
